countdown_phase_sequencer: RTL and testbench
============================================

Name: countdown_phase_sequencer

Overview:
- Controls the 5-to-0 countdown stage.
- Drives that stage's enable, pause and error inputs: bs, vs, pause_o, error_o.
- Consumes its 4-bit BCD output and counts completed laps, where a lap is one 1→0 transition.
- Steps the machine through stage B, then stage V, then done. Handles pause requests, faults and illegal count values.

Parameters:
- LAPS_B, 2, number of completed countdown laps spent in stage B (legal range 1-15).
- LAPS_V, 3, number of completed countdown laps spent in stage V (legal range 1-15).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level; sampled only in IDLE.
- pause_req  input  1  level; pause request from the operator.
- error_in  input  1  level; external fault.
- clear  input  1  level; fault acknowledge.
- bcd  input  4  countdown value from the counter stage.
- bs  output  1  stage-B enable to the counter.
- vs  output  1  stage-V enable to the counter.
- pause_o  output  1  pause to the counter.
- error_o  output  1  error to the counter.
- phase  output  3  current state encoding.
- lap_count  output  4  completed laps in the current stage.
- done  output  1  one-cycle completion pulse.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset, asserted at any time including mid-stage, forces:
  - state=IDLE, lap_count=0, prev_bcd=0, ret_stage=STAGE_B;
  - all outputs to 0.
- Outputs are Moore, decoded from registered state:
  - bs=(STAGE_B); vs=(STAGE_V); pause_o=(PAUSED); error_o=(FAULT); done=(DONE).
  - bs and vs are both 0 in PAUSED.
- phase encoding: IDLE=0, STAGE_B=1, STAGE_V=2, PAUSED=3, FAULT=4, DONE=5. Values 6-7 are unused; if reached, go to FAULT.
- prev_bcd register holds bcd from the previous cycle. It updates every cycle in every state.
- lap_tick = (state is STAGE_B or STAGE_V) && prev_bcd==1 && bcd==0. Purely combinational, evaluated in the same cycle.
- bad_bcd = (state is STAGE_B or STAGE_V) && bcd>5.
- Transition priority within a stage state: error_in or bad_bcd, then pause_req, then lap_tick.
- IDLE:
  - start=1 → STAGE_B, lap_count=0.
  - error_in=1 → FAULT; this takes precedence over start.
- STAGE_B:
  - error or bad_bcd → FAULT.
  - Else pause_req → PAUSED, ret_stage=STAGE_B.
  - Else on lap_tick, lap_count increments. If lap_count+1==LAPS_B → STAGE_V with lap_count=0.
- STAGE_V: same rules as STAGE_B. On the final lap → DONE with lap_count=0.
- PAUSED:
  - error_in → FAULT.
  - Else pause_req=0 → ret_stage.
  - lap_count is held. The partial lap is discarded, because the counter restarts from 0 after resume.
- FAULT:
  - Sticky.
  - clear=1 && error_in=0 → IDLE with lap_count=0.
  - clear while error_in=1 is ignored.
- DONE: lasts exactly one cycle, then → IDLE. start in this cycle is ignored.
- start outside IDLE is ignored.
- pause_req in IDLE, DONE or FAULT is ignored.
- A lap_tick in the same cycle as pause_req is not counted.
- lap_count never exceeds LAPS_x-1 within a stage.
- A stage lasts at least LAPS_x×6 cycles with the 5-to-0 counter: one entry cycle from 0 plus six values per lap.

Test Plan:
The bench drives a behavioural 5-to-0 counter model with the following rules:
- The model is reset to 0 whenever !(bs||vs) || pause_o || error_o.
- Otherwise it steps 0→5, 5→4, …, 1→0.

1. Reset mid-STAGE_V: assert reset asynchronously between edges → phase=0, all outputs 0 immediately without waiting for a clock edge.
2. Nominal run (defaults): start=1 for one cycle → bs=1 for exactly 2 laps (lap_count 0→1), then vs=1 for 3 laps, then done=1 for one cycle → phase=0.
3. Pause: pause_req=1 while in STAGE_B with lap_count=1 and bcd=3, held 4 cycles → pause_o=1, bs=0, lap_count stays 1. On release, returns to STAGE_B; exactly one further full lap is needed to reach STAGE_V.
4. Fault: error_in=1 for one cycle in STAGE_V → phase=4, error_o=1 persists.
   - clear=1 with error_in=1 → stays in FAULT.
   - clear=1 with error_in=0 → phase=0 next cycle.
5. Illegal count: force bcd=7 for one cycle during STAGE_B → FAULT next cycle, error_o=1.
6. Simultaneous events:
   - error_in and pause_req together in STAGE_B → FAULT, not PAUSED.
   - pause_req on the 1→0 edge cycle → PAUSED, lap_count unchanged.
   - start held high through DONE → exactly one restart from IDLE.

Source files
------------

// File: rtl/countdown_phase_sequencer.sv
// Sequences a 5-to-0 countdown stage through stage B, stage V and done, counting 1->0 laps.
// Moore outputs from registered state; faults are sticky until cleared with the fault source gone.
module countdown_phase_sequencer #(
  parameter int unsigned LAPS_B = 2,
  parameter int unsigned LAPS_V = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_req,
  input  logic       error_in,
  input  logic       clear,
  input  logic [3:0] bcd,
  output logic       bs,
  output logic       vs,
  output logic       pause_o,
  output logic       error_o,
  output logic [2:0] phase,
  output logic [3:0] lap_count,
  output logic       done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_B      = 3'd1;
  localparam logic [2:0] ST_V      = 3'd2;
  localparam logic [2:0] ST_PAUSED = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [3:0] TARGET_B = 4'(LAPS_B);
  localparam logic [3:0] TARGET_V = 4'(LAPS_V);

  logic [2:0] state_q, state_d;
  logic [2:0] ret_q, ret_d;
  logic [3:0] lap_q, lap_d;
  logic [3:0] prev_bcd_q;

  logic       in_stage;
  logic       lap_tick;
  logic       bad_bcd;
  logic       last_lap;
  logic [3:0] laps_target;

  assign in_stage    = (state_q == ST_B) || (state_q == ST_V);
  assign lap_tick    = in_stage && (prev_bcd_q == 4'd1) && (bcd == 4'd0);
  assign bad_bcd     = in_stage && (bcd > 4'd5);
  assign laps_target = (state_q == ST_V) ? TARGET_V : TARGET_B;
  assign last_lap    = (lap_q + 4'd1) == laps_target;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_B;
      lap_q      <= 4'd0;
      prev_bcd_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      lap_q      <= lap_d;
      prev_bcd_q <= bcd;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    lap_d   = lap_q;
    case (state_q)
      ST_IDLE: begin
        if (error_in) begin
          state_d = ST_FAULT;
        end else if (start) begin
          state_d = ST_B;
          lap_d   = 4'd0;
        end
      end
      ST_B, ST_V: begin
        if (error_in || bad_bcd) begin
          state_d = ST_FAULT;
        end else if (pause_req) begin
          state_d = ST_PAUSED;
          ret_d   = state_q;
        end else if (lap_tick) begin
          if (last_lap) begin
            state_d = (state_q == ST_B) ? ST_V : ST_DONE;
            lap_d   = 4'd0;
          end else begin
            lap_d = lap_q + 4'd1;
          end
        end
      end
      ST_PAUSED: begin
        // The counter restarts from 0 on resume, so the partial lap is simply dropped.
        if (error_in) begin
          state_d = ST_FAULT;
        end else if (!pause_req) begin
          state_d = ret_q;
        end
      end
      ST_FAULT: begin
        if (clear && !error_in) begin
          state_d = ST_IDLE;
          lap_d   = 4'd0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  always_comb begin
    bs        = (state_q == ST_B);
    vs        = (state_q == ST_V);
    pause_o   = (state_q == ST_PAUSED);
    error_o   = (state_q == ST_FAULT);
    done      = (state_q == ST_DONE);
    phase     = state_q;
    lap_count = lap_q;
  end

endmodule

// File: tb/tb_countdown_phase_sequencer.sv
// Bench for countdown_phase_sequencer: 5-to-0 counter environment, behavioural reference model,
// per-cycle output comparison plus directed scenarios and randomized traffic.
module tb_countdown_phase_sequencer;

  localparam int LAPS_B = 2;
  localparam int LAPS_V = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, pause_req, error_in, clear;
  logic [3:0] bcd;
  logic       bs, vs, pause_o, error_o, done;
  logic [2:0] phase;
  logic [3:0] lap_count;

  logic       force_en;
  logic [3:0] force_val;
  logic [3:0] cnt_q;

  int n_cmp = 0;
  int n_bad = 0;

  countdown_phase_sequencer #(.LAPS_B(LAPS_B), .LAPS_V(LAPS_V)) dut (
    .clock(clock), .reset(reset), .start(start), .pause_req(pause_req),
    .error_in(error_in), .clear(clear), .bcd(bcd), .bs(bs), .vs(vs),
    .pause_o(pause_o), .error_o(error_o), .phase(phase),
    .lap_count(lap_count), .done(done)
  );

  always #5 clock = ~clock;

  // Environment: the 5-to-0 counter stage, restarting from 0 whenever not enabled.
  assign bcd = force_en ? force_val : cnt_q;
  always @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 4'd0;
    else if (!(bs || vs) || pause_o || error_o) cnt_q <= 4'd0;
    else cnt_q <= (cnt_q == 4'd0) ? 4'd5 : cnt_q - 4'd1;
  end

  // Reference model: mode plus stage index (0 = B, 1 = V).
  localparam logic [2:0] M_IDLE = 3'd0, M_RUN = 3'd1, M_PAUSE = 3'd2, M_FAULT = 3'd3, M_DONE = 3'd4;
  typedef struct packed {
    logic [2:0] mode;
    logic       stg;
    logic [3:0] laps;
    logic [3:0] prev;
  } mdl_t;
  localparam mdl_t M_RESET = '{mode: M_IDLE, stg: 1'b0, laps: 4'd0, prev: 4'd0};

  mdl_t m_q;

  function automatic mdl_t mstep(input mdl_t m, input logic st, input logic pr,
                                 input logic er, input logic cl, input logic [3:0] b);
    mdl_t n;
    int need;
    n = m;
    n.prev = b;
    need = m.stg ? LAPS_V : LAPS_B;
    case (m.mode)
      M_IDLE: if (er) n.mode = M_FAULT;
              else if (st) begin n.mode = M_RUN; n.stg = 1'b0; n.laps = 4'd0; end
      M_RUN: begin
        if (er || b > 4'd5) n.mode = M_FAULT;
        else if (pr) n.mode = M_PAUSE;
        else if (m.prev == 4'd1 && b == 4'd0) begin
          if (int'(m.laps) + 1 == need) begin
            n.laps = 4'd0;
            if (m.stg) n.mode = M_DONE;
            else n.stg = 1'b1;
          end else begin
            n.laps = m.laps + 4'd1;
          end
        end
      end
      M_PAUSE: if (er) n.mode = M_FAULT;
               else if (!pr) n.mode = M_RUN;
      M_FAULT: if (cl && !er) begin n.mode = M_IDLE; n.laps = 4'd0; end
      default: n.mode = M_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [11:0] mexp(input mdl_t m);
    logic [2:0] ph;
    case (m.mode)
      M_RUN:   ph = m.stg ? 3'd2 : 3'd1;
      M_PAUSE: ph = 3'd3;
      M_FAULT: ph = 3'd4;
      M_DONE:  ph = 3'd5;
      default: ph = 3'd0;
    endcase
    return {ph, m.laps, (m.mode == M_RUN) && !m.stg, (m.mode == M_RUN) && m.stg,
            m.mode == M_PAUSE, m.mode == M_FAULT, m.mode == M_DONE};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m_q <= M_RESET;
    else m_q <= mstep(m_q, start, pause_req, error_in, clear, bcd);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset)
        chk("model_vs_dut", int'({phase, lap_count, bs, vs, pause_o, error_o, done}), int'(mexp(m_q)));
    end
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic start_run();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_state(input int p, input int lap, input int b, input int budget, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int'(phase) == p && (lap < 0 || int'(lap_count) == lap) && (b < 0 || int'(bcd) == b)) begin
        hit = 1'b1;
        break;
      end
      cyc();
    end
    chk({nm, "_reached"}, int'(hit), 1);
  endtask

  task automatic clear_fault();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    int nb, nv, nd, maxb, maxv, cnt, phold;
    bit fin;
    reset = 1'b1; start = 0; pause_req = 0; error_in = 0; clear = 0;
    force_en = 0; force_val = 4'd0;
    #3;
    chk("reset_vec", int'({phase, lap_count, bs, vs, pause_o, error_o, done}), 0);
    @(negedge clock);
    reset = 1'b0;
    cyc();

    // Nominal run: B needs 13 cycles (entry at 0 plus two laps), V needs 18 (three laps from 5).
    start_run();
    nb = 0; nv = 0; nd = 0; maxb = 0; maxv = 0; fin = 0;
    for (int i = 0; i < 100; i++) begin
      if (phase == 3'd0) begin fin = 1; break; end
      if (bs) begin nb++; if (int'(lap_count) > maxb) maxb = int'(lap_count); end
      if (vs) begin nv++; if (int'(lap_count) > maxv) maxv = int'(lap_count); end
      if (done) nd++;
      cyc();
    end
    chk("nom_finished", int'(fin), 1);
    chk("nom_b_cycles", nb, 13);
    chk("nom_v_cycles", nv, 18);
    chk("nom_done_pulses", nd, 1);
    chk("nom_max_lap_b", maxb, LAPS_B - 1);
    chk("nom_max_lap_v", maxv, LAPS_V - 1);

    // Pause mid second lap of B; resume needs one full lap (0 plus 5..0 = 7 cycles).
    cyc();
    start_run();
    wait_state(1, 1, 3, 40, "pause_point");
    pause_req = 1'b1;
    repeat (4) begin
      cyc();
      chk("pause_o", int'(pause_o), 1);
      chk("pause_bs", int'(bs), 0);
      chk("pause_lap", int'(lap_count), 1);
    end
    pause_req = 1'b0;
    cyc();
    chk("resume_lap", int'(lap_count), 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (phase == 3'd2) break;
      if (bs) cnt++;
      cyc();
    end
    chk("resume_b_cycles", cnt, 7);
    wait_state(0, -1, -1, 100, "pause_run_end");

    // Fault in V, sticky until clear with error_in low.
    start_run();
    wait_state(2, -1, -1, 60, "fault_v");
    error_in = 1'b1;
    cyc();
    error_in = 1'b0;
    chk("fault_phase", int'(phase), 4);
    chk("fault_error_o", int'(error_o), 1);
    cyc();
    chk("fault_sticky", int'(phase), 4);
    clear = 1'b1; error_in = 1'b1;
    cyc();
    chk("fault_clear_ignored", int'(phase), 4);
    error_in = 1'b0;
    cyc();
    clear = 1'b0;
    chk("fault_cleared", int'(phase), 0);

    // Illegal count value in B.
    start_run();
    cyc(); cyc();
    force_en = 1'b1; force_val = 4'd7;
    cyc();
    force_en = 1'b0;
    chk("bad_bcd_phase", int'(phase), 4);
    chk("bad_bcd_error_o", int'(error_o), 1);
    clear_fault();
    chk("bad_bcd_cleared", int'(phase), 0);

    // error_in and pause_req together: fault wins.
    start_run();
    cyc();
    error_in = 1'b1; pause_req = 1'b1;
    cyc();
    error_in = 1'b0; pause_req = 1'b0;
    chk("err_over_pause", int'(phase), 4);
    clear_fault();

    // pause_req on the 1->0 cycle: lap is not counted.
    start_run();
    wait_state(1, 0, 1, 40, "tick_point");
    cyc();
    pause_req = 1'b1;
    cyc();
    pause_req = 1'b0;
    chk("tick_pause_phase", int'(phase), 3);
    chk("tick_pause_lap", int'(lap_count), 0);

    // start held through DONE: one IDLE cycle, then exactly one restart.
    wait_state(5, -1, -1, 120, "done_hold");
    start = 1'b1;
    cyc();
    chk("done_start_ignored", int'(phase), 0);
    cyc();
    start = 1'b0;
    chk("restart_from_idle", int'(phase), 1);

    // Asynchronous reset in the middle of V.
    wait_state(2, -1, -1, 60, "reset_v");
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_vec", int'({phase, lap_count, bs, vs, pause_o, error_o, done}), 0);
    #1 reset = 1'b0;
    cyc();

    // Randomized traffic against the model.
    phold = 0;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 6 == 0);
      if (phold > 0) begin
        phold--;
        pause_req = 1'b1;
      end else begin
        pause_req = 1'b0;
        if ($urandom % 25 == 0) phold = int'($urandom_range(1, 6));
      end
      error_in = ($urandom % 150 == 0);
      clear = ($urandom % 3 == 0);
      force_en = ($urandom % 250 == 0);
      force_val = 4'($urandom % 16);
      cyc();
    end
    start = 0; pause_req = 0; error_in = 0; clear = 0; force_en = 0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
